// File: rtl/tdc_time_fifo.sv
// ---------------------------------------------------------------------------
// tdc_time_fifo
//
// Result buffer behind the TDC register read/write stage. Every time word the
// stage presents with its read-over pulse is inspected. Words addressed to
// result FIFO 8 or 9 go into a first-word-fall-through circular queue that
// the bus side drains with pop_in. All other words are rejected, and the
// rejection is flagged for one cycle. The block also reports the fill level,
// a level-sensitive threshold interrupt and a saturating count of words lost
// because the queue was full.
//
// Parameters
//   DEPTH_LOG2  queue depth is 2**DEPTH_LOG2 words
//   IRQ_LEVEL   irq_out asserts when the stored count is at least this value
//               (1 .. 2**DEPTH_LOG2)
//   DROP_W      width of the overflow drop counter
//
// Ports
//   clk          system clock
//   resetn       synchronous active-low reset, overrides everything
//   timeData_in  upstream word: [31:28] TDC address, [27:0] raw result
//   rdOver_in    upstream read-over pulse, qualifies timeData_in
//   pop_in       consumer removes the head word (ignored while empty)
//   clear_in     synchronous flush of queue and drop counter
//   data_out     head word, 0 while empty
//   valid_out    queue not empty
//   count_out    number of stored words (0 .. 2**DEPTH_LOG2)
//   full_out     queue holds 2**DEPTH_LOG2 words
//   irq_out      count_out >= IRQ_LEVEL
//   dropCnt_out  words lost to a full queue, saturates at all-ones
//   badAddr_out  one-cycle pulse after a word with a foreign address arrived
// ---------------------------------------------------------------------------
module tdc_time_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 8,
    parameter int DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           timeData_in,
    input  logic                  rdOver_in,
    input  logic                  pop_in,
    input  logic                  clear_in,
    output logic [31:0]           data_out,
    output logic                  valid_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  full_out,
    output logic                  irq_out,
    output logic [DROP_W-1:0]     dropCnt_out,
    output logic                  badAddr_out
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      IRQ_CNT  = CNT_W'(IRQ_LEVEL);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DROP_W-1:0]     DROP_ONE = DROP_W'(1);

    // Storage and state registers
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DROP_W-1:0]     dropCnt_q, dropCnt_d;
    logic                  badAddr_q, badAddr_d;

    // Decoded request qualifiers
    logic addrOk;
    logic isFull;
    logic isEmpty;
    logic popDo;
    logic pushReq;
    logic pushDo;
    logic pushDrop;
    logic memWe;

    // Classify this cycle's requests. A push into a full queue is still
    // accepted when a real pop frees the head slot in the same edge; only
    // otherwise is it counted as a drop. A pop on an empty queue is ignored,
    // so push+pop on empty degenerates to a plain push.
    always_comb begin
        addrOk   = (timeData_in[31:28] == 4'h8) || (timeData_in[31:28] == 4'h9);
        isFull   = (count_q == FULL_CNT);
        isEmpty  = (count_q == '0);
        popDo    = pop_in && !isEmpty;
        pushReq  = rdOver_in && addrOk;
        pushDo   = pushReq && (!isFull || popDo);
        pushDrop = pushReq && isFull && !popDo;
        memWe    = pushDo && !clear_in;
    end

    // Next-state computation. Clear wins over push and pop but must not hide
    // a rejected word, so the bad-address flag is derived outside the clear
    // branch.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        dropCnt_d = dropCnt_q;
        badAddr_d = rdOver_in && !addrOk;

        if (clear_in) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            dropCnt_d = '0;
        end else begin
            if (pushDo) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (popDo) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (pushDo && !popDo) begin
                count_d = count_q + CNT_ONE;
            end else if (popDo && !pushDo) begin
                count_d = count_q - CNT_ONE;
            end
            if (pushDrop && (dropCnt_q != '1)) begin
                dropCnt_d = dropCnt_q + DROP_ONE;
            end
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            dropCnt_q <= '0;
            badAddr_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            dropCnt_q <= dropCnt_d;
            badAddr_q <= badAddr_d;
        end
    end

    // Word storage. Not reset: its contents only become visible through
    // data_out once count_q says a slot holds a written word. When the queue
    // is full and a push coincides with a pop, wrPtr equals rdPtr; the head
    // word is read out before this edge overwrites it.
    always_ff @(posedge clk) begin
        if (resetn && memWe) begin
            mem_q[wrPtr_q] <= timeData_in;
        end
    end

    // Outputs come from registered state only, so pop_in and rdOver_in
    // have no combinational path to them.
    always_comb begin
        valid_out   = !isEmpty;
        full_out    = isFull;
        irq_out     = (count_q >= IRQ_CNT);
        count_out   = count_q;
        dropCnt_out = dropCnt_q;
        badAddr_out = badAddr_q;
        data_out    = isEmpty ? 32'h0 : mem_q[rdPtr_q];
    end

endmodule

// File: tb/tb_tdc_time_fifo.sv
// ---------------------------------------------------------------------------
// tb_tdc_time_fifo
//
// Bench for tdc_time_fifo. A queue-based model tracks which words must be
// stored, the drop count and the bad-address flag. A compare process checks
// every DUT output against that model on each falling clock edge. Directed
// sequences with literal expectations come first, followed by randomized
// traffic.
// ---------------------------------------------------------------------------
module tb_tdc_time_fifo;

    localparam int DEPTH    = 16;
    localparam int IRQ_LVL  = 8;
    localparam int DROP_MAX = 65535;

    logic        clk;
    logic        resetn;
    logic [31:0] timeData_in;
    logic        rdOver_in;
    logic        pop_in;
    logic        clear_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic [4:0]  count_out;
    logic        full_out;
    logic        irq_out;
    logic [15:0] dropCnt_out;
    logic        badAddr_out;

    int vectors;
    int miscompares;
    bit checkEn;

    // Reference model state
    logic [31:0] modelQ[$];
    int          modelDrop;
    bit          modelBad;

    tdc_time_fifo #(
        .DEPTH_LOG2 (4),
        .IRQ_LEVEL  (IRQ_LVL),
        .DROP_W     (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .timeData_in (timeData_in),
        .rdOver_in   (rdOver_in),
        .pop_in      (pop_in),
        .clear_in    (clear_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .count_out   (count_out),
        .full_out    (full_out),
        .irq_out     (irq_out),
        .dropCnt_out (dropCnt_out),
        .badAddr_out (badAddr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model update from the rules: what the queue contents must be after an
    // edge with these inputs.
    task automatic modelStep(input bit rstn, input bit rd, input logic [31:0] d,
                             input bit pop, input bit clr);
        bit ok;
        bit popDo;
        if (!rstn) begin
            modelQ.delete();
            modelDrop = 0;
            modelBad  = 0;
            return;
        end
        ok       = (d[31:28] == 4'h8) || (d[31:28] == 4'h9);
        modelBad = rd && !ok;
        if (clr) begin
            modelQ.delete();
            modelDrop = 0;
            return;
        end
        popDo = pop && (modelQ.size() > 0);
        if (popDo) void'(modelQ.pop_front());
        if (rd && ok) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(d);
            else if (modelDrop < DROP_MAX) modelDrop++;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    // Inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input bit rstn, input bit rd, input logic [31:0] d,
                                 input bit pop, input bit clr);
        resetn      = rstn;
        rdOver_in   = rd;
        timeData_in = d;
        pop_in      = pop;
        clear_in    = clr;
        @(posedge clk);
        #1;
        modelStep(rstn, rd, d, pop, clr);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic popOne();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("data_out", data_out,
                        (modelQ.size() > 0) ? modelQ[0] : 32'h0);
            checkOutput("valid_out", {31'h0, valid_out}, {31'h0, modelQ.size() > 0});
            checkOutput("count_out", {27'h0, count_out}, modelQ.size());
            checkOutput("full_out", {31'h0, full_out}, {31'h0, modelQ.size() == DEPTH});
            checkOutput("irq_out", {31'h0, irq_out}, {31'h0, modelQ.size() >= IRQ_LVL});
            checkOutput("dropCnt_out", {16'h0, dropCnt_out}, modelDrop);
            checkOutput("badAddr_out", {31'h0, badAddr_out}, {31'h0, modelBad});
        end
    end

    initial begin
        logic [31:0] d;
        int          r;
        int          pushPct;
        int          popPct;

        vectors     = 0;
        miscompares = 0;
        checkEn     = 0;
        modelDrop   = 0;
        modelBad    = 0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkEn = 1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset count", {27'h0, count_out}, 32'd0);
        checkOutput("reset data", data_out, 32'h0);
        idle();

        // Single push then pop
        push(32'h8000_1234);
        checkOutput("single data", data_out, 32'h8000_1234);
        checkOutput("single count", {27'h0, count_out}, 32'd1);
        checkOutput("single valid", {31'h0, valid_out}, 32'd1);
        popOne();
        checkOutput("single pop valid", {31'h0, valid_out}, 32'd0);
        checkOutput("single pop data", data_out, 32'h0);

        // Fill back-to-back, irq on the 8th push
        for (int i = 0; i < 16; i++) begin
            push(32'h9000_0000 + 32'(i));
            if (i == 6) checkOutput("irq before 8th", {31'h0, irq_out}, 32'd0);
            if (i == 7) checkOutput("irq at 8th", {31'h0, irq_out}, 32'd1);
        end
        checkOutput("fill full", {31'h0, full_out}, 32'd1);
        checkOutput("fill count", {27'h0, count_out}, 32'd16);
        for (int i = 0; i < 3; i++) push(32'h9100_0000 + 32'(i));
        checkOutput("overflow drop", {16'h0, dropCnt_out}, 32'd3);
        checkOutput("overflow count", {27'h0, count_out}, 32'd16);
        checkOutput("overflow head", data_out, 32'h9000_0000);

        // Full with simultaneous push and pop
        applyStimulus(1'b1, 1'b1, 32'h8ABC_DEF0, 1'b1, 1'b0);
        checkOutput("fullpp count", {27'h0, count_out}, 32'd16);
        checkOutput("fullpp drop", {16'h0, dropCnt_out}, 32'd3);
        checkOutput("fullpp head", data_out, 32'h9000_0001);
        for (int i = 0; i < 15; i++) popOne();
        checkOutput("fullpp 16th", data_out, 32'h8ABC_DEF0);
        popOne();
        checkOutput("drain empty", {31'h0, valid_out}, 32'd0);

        // Bad addresses
        push(32'h3000_0001);
        checkOutput("bad pulse", {31'h0, badAddr_out}, 32'd1);
        checkOutput("bad count", {27'h0, count_out}, 32'd0);
        idle();
        checkOutput("bad pulse end", {31'h0, badAddr_out}, 32'd0);
        push(32'hF000_0000);
        checkOutput("bad F pulse", {31'h0, badAddr_out}, 32'd1);
        checkOutput("bad F drop", {16'h0, dropCnt_out}, 32'd3);
        idle();

        // Clear priority with count=5, drops=2
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) push(32'h8200_0000 + 32'(i));
        for (int i = 0; i < 11; i++) popOne();
        checkOutput("preclear count", {27'h0, count_out}, 32'd5);
        checkOutput("preclear drop", {16'h0, dropCnt_out}, 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h8777_7777, 1'b0, 1'b1);
        checkOutput("clear count", {27'h0, count_out}, 32'd0);
        checkOutput("clear drop", {16'h0, dropCnt_out}, 32'd0);
        checkOutput("clear valid", {31'h0, valid_out}, 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) push(32'h9300_0000 + 32'(i));
        applyStimulus(1'b0, 1'b1, 32'h3000_0000, 1'b1, 1'b0);
        checkOutput("rst count", {27'h0, count_out}, 32'd0);
        checkOutput("rst bad", {31'h0, badAddr_out}, 32'd0);
        checkOutput("rst data", data_out, 32'h0);

        // Pointer wrap with push/pop pairs
        for (int i = 0; i < 40; i++) begin
            push(32'h8400_0000 + 32'(i * 7));
            checkOutput("wrap data", data_out, 32'h8400_0000 + 32'(i * 7));
            popOne();
        end
        checkOutput("wrap end count", {27'h0, count_out}, 32'd0);

        // Randomized traffic with varying fill pressure
        for (int phase = 0; phase < 8; phase++) begin
            pushPct = (phase % 2 == 0) ? 80 : 30;
            popPct  = (phase % 2 == 0) ? 25 : 70;
            for (int c = 0; c < 250; c++) begin
                r = int'($urandom_range(0, 9));
                d[27:0]  = 28'($urandom);
                d[31:28] = (r < 4) ? 4'h8 : (r < 8) ? 4'h9 : 4'($urandom);
                applyStimulus(($urandom_range(0, 499) != 0),
                              (int'($urandom_range(0, 99)) < pushPct), d,
                              (int'($urandom_range(0, 99)) < popPct),
                              ($urandom_range(0, 149) == 0));
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
